// File: rtl/time_pkg.sv
// Shared time-of-day constants and BCD digit layout.
// Shared with the display/alarm driver and the alarm-set block.
package time_pkg;

  // Digit field positions within a 16-bit HH:MM word.
  localparam int HT_LSB = 12;
  localparam int HU_LSB = 8;
  localparam int MT_LSB = 4;
  localparam int MU_LSB = 0;

  localparam logic [3:0] MAX_HOUR_TENS       = 4'd2;
  localparam logic [3:0] MAX_HOUR_UNITS_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MIN_TENS        = 4'd5;
  localparam logic [3:0] MAX_UNITS           = 4'd9;

  localparam logic [15:0] RESET_TIME = 16'h0000;

  // ht=[15:12] hu=[11:8] mt=[7:4] mu=[3:0]
  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] mt;
    logic [3:0] mu;
  } bcd_time_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter: enable, sync clear (priority), terminal count.
// Ports: clk, rst (async high), en, clr, tc (count == N-1).
module mod_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count;

  assign tc = (count == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD HH:MM time-of-day counter with second/minute strobes.
// Ports: clk, reset, load_time, new_time, fast_watch -> current_time,
//   one_second, one_minute, load_error (all outputs registered).
module time_counter
  import time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 256,
  parameter int SECS_PER_MIN  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_time,
  input  logic [15:0] new_time,
  input  logic        fast_watch,
  output logic [15:0] current_time,
  output logic        one_second,
  output logic        one_minute,
  output logic        load_error
);

  function automatic logic bcd_valid(input logic [15:0] v);
    bcd_time_t t;
    logic      hu_ok;
    t     = bcd_time_t'(v);
    hu_ok = (t.ht == MAX_HOUR_TENS) ? (t.hu <= MAX_HOUR_UNITS_AT_2)
                                    : (t.hu <= MAX_UNITS);
    return (t.ht <= MAX_HOUR_TENS) && hu_ok &&
           (t.mt <= MAX_MIN_TENS) && (t.mu <= MAX_UNITS);
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    bcd_time_t t;
    t = bcd_time_t'(v);
    if (t.mu != MAX_UNITS) begin
      t.mu = t.mu + 4'd1;
    end else begin
      t.mu = 4'd0;
      if (t.mt != MAX_MIN_TENS) begin
        t.mt = t.mt + 4'd1;
      end else begin
        t.mt = 4'd0;
        if (t.ht == MAX_HOUR_TENS && t.hu == MAX_HOUR_UNITS_AT_2) begin
          t.ht = 4'd0;
          t.hu = 4'd0;
        end else if (t.hu == MAX_UNITS) begin
          t.hu = 4'd0;
          t.ht = t.ht + 4'd1;
        end else begin
          t.hu = t.hu + 4'd1;
        end
      end
    end
    return 16'(t);
  endfunction

  logic new_ok;
  logic load_ok;
  logic load_bad;
  logic pre_tc;
  logic sec_tc;
  logic sec_tick;
  logic min_tick;

  assign new_ok   = bcd_valid(new_time);
  assign load_ok  = load_time & new_ok;
  assign load_bad = load_time & ~new_ok;

  // A valid load swallows any tick landing in the same cycle.
  assign sec_tick = pre_tc & ~load_ok;
  assign min_tick = sec_tick & (fast_watch | sec_tc);

  mod_counter #(.N(TICKS_PER_SEC)) u_prescaler (
    .clk (clk),
    .rst (reset),
    .en  (1'b1),
    .clr (load_ok),
    .tc  (pre_tc)
  );

  mod_counter #(.N(SECS_PER_MIN)) u_seconds (
    .clk (clk),
    .rst (reset),
    .en  (pre_tc),
    .clr (load_ok),
    .tc  (sec_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_time <= RESET_TIME;
      one_second   <= 1'b0;
      one_minute   <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      one_second <= sec_tick;
      one_minute <= min_tick;
      load_error <= load_bad;
      if (load_ok) begin
        current_time <= new_time;
      end else if (min_tick) begin
        current_time <= bcd_inc(current_time);
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter, TICKS_PER_SEC=4, SECS_PER_MIN=3.
// Table of load vectors plus hand sequences for tick collisions.
module tb_time_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_time;
  logic [15:0] new_time;
  logic        fast_watch;
  logic [15:0] current_time;
  logic        one_second;
  logic        one_minute;
  logic        load_error;

  int checks = 0;
  int failures = 0;

  time_counter #(.TICKS_PER_SEC(4), .SECS_PER_MIN(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_time    (load_time),
    .new_time     (new_time),
    .fast_watch   (fast_watch),
    .current_time (current_time),
    .one_second   (one_second),
    .one_minute   (one_minute),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ld;
    logic        err;
    logic [15:0] after;
    logic [15:0] nxt;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step negedges until one_minute (bounded); note any load_error.
  task automatic wait_min(output int cyc, output logic err_seen);
    cyc = 0;
    err_seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (load_error) err_seen = 1'b1;
    end while (!one_minute && cyc < 40);
  endtask

  int   cyc;
  int   nsec;
  logic es;
  logic bad;

  initial begin
    vecs[0] = '{16'h2359, 1'b0, 16'h2359, 16'h0000, 12};
    vecs[1] = '{16'h2400, 1'b1, 16'h0000, 16'h0001, 11};
    vecs[2] = '{16'h0959, 1'b0, 16'h0959, 16'h1000, 12};
    vecs[3] = '{16'h1959, 1'b0, 16'h1959, 16'h2000, 12};
    vecs[4] = '{16'h0009, 1'b0, 16'h0009, 16'h0010, 12};
    vecs[5] = '{16'h1260, 1'b1, 16'h0010, 16'h0011, 11};
    vecs[6] = '{16'h0A00, 1'b1, 16'h0011, 16'h0012, 11};
    vecs[7] = '{16'h0059, 1'b0, 16'h0059, 16'h0100, 12};
    vecs[8] = '{16'h2300, 1'b0, 16'h2300, 16'h2301, 12};
    vecs[9] = '{16'h3000, 1'b1, 16'h2301, 16'h2302, 11};

    reset = 1'b1;
    load_time = 1'b0;
    new_time = 16'h0000;
    fast_watch = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_time", 32'(current_time), 32'h0000);
    chk("rst_pulses", {29'd0, one_second, one_minute, load_error}, 32'd0);
    reset = 1'b0;

    // First one_second after the 4th edge; minute after the 12th.
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!one_second && cyc < 20);
    chk("first_sec_cyc", 32'(cyc), 32'd4);
    nsec = 1;
    bad = one_minute;
    repeat (8) begin
      @(negedge clk);
      cyc++;
      if (one_second) nsec++;
      if (one_minute && cyc != 12) bad = 1'b1;
    end
    chk("secs_in_min", 32'(nsec), 32'd3);
    chk("early_minute", {31'd0, bad}, 32'd0);
    chk("min1_pulse", {31'd0, one_minute}, 32'd1);
    chk("min1_time", 32'(current_time), 32'h0001);

    for (int i = 0; i < 10; i++) begin
      load_time = 1'b1;
      new_time = vecs[i].ld;
      @(negedge clk);
      load_time = 1'b0;
      chk($sformatf("v%0d_err", i), {31'd0, load_error},
          {31'd0, vecs[i].err});
      chk($sformatf("v%0d_after", i), 32'(current_time),
          32'(vecs[i].after));
      wait_min(cyc, es);
      chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("v%0d_next", i), 32'(current_time),
          32'(vecs[i].nxt));
      chk($sformatf("v%0d_errclr", i), {31'd0, es}, 32'd0);
    end

    // Valid load on the edge of a scheduled minute tick.
    repeat (11) @(negedge clk);
    load_time = 1'b1;
    new_time = 16'h1200;
    @(negedge clk);
    load_time = 1'b0;
    chk("coll_v_time", 32'(current_time), 32'h1200);
    chk("coll_v_pulses", {30'd0, one_minute, one_second}, 32'd0);
    wait_min(cyc, es);
    chk("coll_v_cyc", 32'(cyc), 32'd12);
    chk("coll_v_next", 32'(current_time), 32'h1201);

    // Invalid load on a minute tick: tick proceeds, error pulses.
    repeat (11) @(negedge clk);
    load_time = 1'b1;
    new_time = 16'h2400;
    @(negedge clk);
    load_time = 1'b0;
    chk("coll_i_time", 32'(current_time), 32'h1202);
    chk("coll_i_min", {31'd0, one_minute}, 32'd1);
    chk("coll_i_err", {31'd0, load_error}, 32'd1);

    // Held valid load freezes time.
    load_time = 1'b1;
    new_time = 16'h0800;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (current_time !== 16'h0800 || one_second || one_minute)
        bad = 1'b1;
    end
    load_time = 1'b0;
    chk("hold_frozen", {31'd0, bad}, 32'd0);
    wait_min(cyc, es);
    chk("hold_cyc", 32'(cyc), 32'd12);
    chk("hold_next", 32'(current_time), 32'h0801);

    // Fast-forward: a minute on every second.
    load_time = 1'b1;
    new_time = 16'h0000;
    fast_watch = 1'b1;
    @(negedge clk);
    load_time = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_min(cyc, es);
      chk($sformatf("fast%0d_cyc", k), 32'(cyc), 32'd4);
      chk($sformatf("fast%0d_sec", k), {31'd0, one_second}, 32'd1);
      chk($sformatf("fast%0d_time", k), 32'(current_time), 32'(k));
    end

    // Asynchronous reset between edges.
    #1 reset = 1'b1;
    #1;
    chk("arst_time", 32'(current_time), 32'h0000);
    chk("arst_pulses", {29'd0, one_second, one_minute, load_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fast_watch = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!one_second && cyc < 20);
    chk("arst_sec_cyc", 32'(cyc), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
